// File: rtl/univ_shift_pkg.sv
// Shared types and helpers for the universal shift register.
package univ_shift_pkg;

  typedef enum logic [2:0] {
    OP_SHL = 3'd0,
    OP_SHR = 3'd1,
    OP_ROL = 3'd2,
    OP_ROR = 3'd3,
    OP_ASR = 3'd4
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  function automatic int unsigned clamp_shamt(input int unsigned amt, input int unsigned width);
    return (amt > width) ? width : amt;
  endfunction

endpackage

// File: rtl/univ_shift_step.sv
// Single-bit shift/rotate step; reserved opcodes hold both data and sout.
module univ_shift_step
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [2:0]       op_i,
  input  logic             sin_i,
  input  logic             sout_i,
  output logic [WIDTH-1:0] data_o,
  output logic             sout_o
);

  always_comb begin
    data_o = data_i;
    sout_o = sout_i;
    case (op_i)
      OP_SHL: begin
        data_o = {data_i[WIDTH-2:0], sin_i};
        sout_o = data_i[WIDTH-1];
      end
      OP_SHR: begin
        data_o = {sin_i, data_i[WIDTH-1:1]};
        sout_o = data_i[0];
      end
      OP_ROL: begin
        data_o = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
        sout_o = data_i[WIDTH-1];
      end
      OP_ROR: begin
        data_o = {data_i[0], data_i[WIDTH-1:1]};
        sout_o = data_i[0];
      end
      OP_ASR: begin
        data_o = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
        sout_o = data_i[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load, serial multi-cycle shift/rotate with busy/done.
// Define UNIV_SHIFT_BARREL_EN to complete any shift in a single edge via a barrel chain.
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [SHW-1:0]   shamt,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [SHW-1:0]   rem_q, rem_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;

  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] step_q;
  logic             step_sout;

  assign amt = SHW'(clamp_shamt(32'(shamt), 32'(WIDTH)));

  univ_shift_step #(.WIDTH(WIDTH)) u_step (
    .data_i (q_q),
    .op_i   (op_q),
    .sin_i  (sin),
    .sout_i (sout_q),
    .data_o (step_q),
    .sout_o (step_sout)
  );

`ifdef UNIV_SHIFT_BARREL_EN
  logic [WIDTH-1:0] chain_q    [WIDTH+1];
  logic             chain_sout [WIDTH+1];
  logic [WIDTH-1:0] barrel_q;
  logic             barrel_sout;

  assign chain_q[0]    = q_q;
  assign chain_sout[0] = sout_q;

  // Stage i holds the result after i serial steps, so sout tracks serial order exactly.
  for (genvar i = 0; i < WIDTH; i++) begin : g_barrel
    univ_shift_step #(.WIDTH(WIDTH)) u_bstep (
      .data_i (chain_q[i]),
      .op_i   (op),
      .sin_i  (sin),
      .sout_i (chain_sout[i]),
      .data_o (chain_q[i+1]),
      .sout_o (chain_sout[i+1])
    );
  end

  always_comb begin
    barrel_q    = q_q;
    barrel_sout = sout_q;
    for (int unsigned i = 0; i <= WIDTH; i++) begin
      if (amt == SHW'(i)) begin
        barrel_q    = chain_q[i];
        barrel_sout = chain_sout[i];
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    op_d    = op_q;
    q_d     = q_q;
    sout_d  = sout_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          q_d = d;
        end else if (start) begin
          op_d = op;
`ifdef UNIV_SHIFT_BARREL_EN
          q_d    = barrel_q;
          sout_d = barrel_sout;
          done_d = 1'b1;
`else
          if (amt == '0) begin
            done_d = 1'b1;
          end else begin
            rem_d   = amt;
            state_d = ST_SHIFT;
          end
`endif
        end
      end
      ST_SHIFT: begin
        q_d    = step_q;
        sout_d = step_sout;
        rem_d  = rem_q - SHW'(1);
        if (rem_q == SHW'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      op_q    <= '0;
      q_q     <= '0;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      q_q     <= q_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
    end
  end

  assign q    = q_q;
  assign sout = sout_q;
  assign busy = (state_q == ST_SHIFT);
  assign done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (serial or UNIV_SHIFT_BARREL_EN build).
module tb_univ_shift_reg;

  localparam int W  = 8;
  localparam int SW = $clog2(W) + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          load;
  logic [W-1:0]  d;
  logic          start;
  logic [2:0]    op;
  logic [SW-1:0] shamt;
  logic          sin;
  logic [W-1:0]  q;
  logic          sout;
  logic          busy;
  logic          done;

  int n_vec  = 0;
  int n_miss = 0;

  logic [W-1:0] m_q    = '0;
  logic         m_sout = 1'b0;

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .d       (d),
    .start   (start),
    .op      (op),
    .shamt   (shamt),
    .sin     (sin),
    .q       (q),
    .sout    (sout),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Reference: the whole n-bit operation computed in one go with integer arithmetic.
  task automatic model_op(input logic [2:0] o, input int unsigned n, input logic s);
    int unsigned v, mask, r, top;
    logic so;
    if (n == 0 || o > 3'd4) return;
    v    = m_q;
    mask = (1 << W) - 1;
    top  = mask & ~((1 << (W - n)) - 1);
    r    = v;
    so   = m_sout;
    case (o)
      3'd0: begin r = ((v << n) | (s ? (1 << n) - 1 : 0)) & mask;  so = ((v >> (W - n)) & 1) != 0; end
      3'd1: begin r = (v >> n) | (s ? top : 0);                    so = ((v >> (n - 1)) & 1) != 0; end
      3'd2: begin r = ((v << n) | (v >> (W - n))) & mask;          so = ((v >> (W - n)) & 1) != 0; end
      3'd3: begin r = ((v >> n) | (v << (W - n))) & mask;          so = ((v >> (n - 1)) & 1) != 0; end
      default: begin r = (v >> n) | (((v >> (W - 1)) & 1) != 0 ? top : 0); so = ((v >> (n - 1)) & 1) != 0; end
    endcase
    m_q    = W'(r);
    m_sout = so;
  endtask

  task automatic do_load(input logic [W-1:0] val);
    load = 1'b1;
    d    = val;
    @(posedge clk); #1;
    load = 1'b0;
    d    = W'($urandom);
    m_q  = val;
    n_vec++;
    if (q !== m_q) begin n_miss++; $display("FAIL load_q: got %h expected %h", q, m_q); end
  endtask

  // Caller is #1 after an edge; start is driven immediately, so chained calls are back-to-back.
  task automatic run_op(input logic [2:0] o, input int unsigned sh, input logic s);
    int unsigned n;
    int          busy_cnt;
    int          exp_busy;
    bit          seen;
    n        = (sh > W) ? W : sh;
    busy_cnt = 0;
    seen     = 0;
`ifdef UNIV_SHIFT_BARREL_EN
    exp_busy = 0;
`else
    exp_busy = int'(n);
`endif
    start = 1'b1;
    op    = o;
    shamt = SW'(sh);
    sin   = s;
    @(posedge clk); #1;
    start = 1'b0;
    op    = 3'($urandom);
    shamt = SW'($urandom);
    model_op(o, n, s);
    for (int c = 0; c < 40; c++) begin
      if (busy) busy_cnt++;
      if (done) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    n_vec++;
    if (!seen) begin n_miss++; $display("FAIL op_done_timeout: op %0d shamt %0d got no done, expected done", o, sh); end
    n_vec++;
    if (busy_cnt != exp_busy) begin n_miss++; $display("FAIL op_busy_cycles: op %0d shamt %0d got %0d expected %0d", o, sh, busy_cnt, exp_busy); end
    n_vec++;
    if (busy !== 1'b0) begin n_miss++; $display("FAIL op_busy_at_done: got %b expected 0", busy); end
    n_vec++;
    if (q !== m_q) begin n_miss++; $display("FAIL op_q: op %0d shamt %0d sin %b got %h expected %h", o, sh, s, q, m_q); end
    n_vec++;
    if (sout !== m_sout) begin n_miss++; $display("FAIL op_sout: op %0d shamt %0d got %b expected %b", o, sh, sout, m_sout); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; load = 1'b0; start = 1'b0; d = '0; op = '0; shamt = '0; sin = 1'b0;
    #12;
    n_vec++;
    if (q !== '0) begin n_miss++; $display("FAIL reset_q: got %h expected 00", q); end
    n_vec++;
    if ({busy, done, sout} !== 3'b000) begin n_miss++; $display("FAIL reset_flags: busy/done/sout got %b expected 000", {busy, done, sout}); end
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_load_shl();
    do_load(8'hA5);
    run_op(3'd0, 3, 1'b1);
    n_vec++;
    if (q !== 8'h2F || sout !== 1'b1) begin n_miss++; $display("FAIL shl3_const: got %h/%b expected 2f/1", q, sout); end
  endtask

  task automatic test_rotate_asr();
    do_load(8'h81);
    run_op(3'd3, 1, 1'b0);
    n_vec++;
    if (q !== 8'hC0 || sout !== 1'b1) begin n_miss++; $display("FAIL ror1_const: got %h/%b expected c0/1", q, sout); end
    do_load(8'h80);
    run_op(3'd4, 2, 1'b1);
    n_vec++;
    if (q !== 8'hE0 || sout !== 1'b0) begin n_miss++; $display("FAIL asr2_const: got %h/%b expected e0/0", q, sout); end
  endtask

  task automatic test_priority();
    int dn;
    dn = 0;
    load = 1'b1; start = 1'b1; d = 8'h3C; op = 3'd0; shamt = SW'(3); sin = 1'b1;
    @(posedge clk); #1;
    load = 1'b0; start = 1'b0;
    m_q = 8'h3C;
    if (busy || done) dn++;
    @(posedge clk); #1;
    if (busy || done) dn++;
    n_vec++;
    if (q !== 8'h3C) begin n_miss++; $display("FAIL prio_q: got %h expected 3c", q); end
    n_vec++;
    if (dn != 0) begin n_miss++; $display("FAIL prio_no_busy_done: got %0d active cycles expected 0", dn); end
  endtask

  task automatic test_clamp();
    do_load(8'hFF);
    run_op(3'd0, 12, 1'b0);
    n_vec++;
    if (q !== 8'h00 || sout !== 1'b1) begin n_miss++; $display("FAIL clamp_const: got %h/%b expected 00/1", q, sout); end
  endtask

  task automatic test_zero_back_to_back();
    do_load(8'h5A);
    run_op(3'd1, 0, 1'b1);
    n_vec++;
    if (q !== 8'h5A) begin n_miss++; $display("FAIL zero_q: got %h expected 5a", q); end
    run_op(3'd2, 3, 1'b0);
    run_op(3'd1, 2, 1'b1);
    run_op(3'd6, 3, 1'b1);
    @(posedge clk); #1;
    n_vec++;
    if (done !== 1'b0) begin n_miss++; $display("FAIL done_one_cycle: got %b expected 0", done); end
  endtask

  task automatic test_ignored_during_shift();
`ifndef UNIV_SHIFT_BARREL_EN
    do_load(8'h96);
    start = 1'b1; op = 3'd2; shamt = SW'(6); sin = 1'b0;
    @(posedge clk); #1;
    model_op(3'd2, 6, 1'b0);
    load = 1'b1; d = 8'h00; op = 3'd1; shamt = SW'(1);
    repeat (3) begin @(posedge clk); #1; end
    load = 1'b0; start = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin @(posedge clk); #1; end
    n_vec++;
    if (q !== m_q || sout !== m_sout || done !== 1'b1) begin
      n_miss++; $display("FAIL ignore_in_shift: got %h/%b done %b expected %h/%b done 1", q, sout, done, m_q, m_sout);
    end
`endif
  endtask

  task automatic test_reset_mid_shift();
    int dn;
    dn = 0;
    do_load(8'hA5);
    start = 1'b1; op = 3'd0; shamt = SW'(5); sin = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    #2 reset_n = 1'b0;
    #1;
    m_q = '0; m_sout = 1'b0;
    n_vec++;
    if (q !== '0 || busy !== 1'b0 || sout !== 1'b0) begin n_miss++; $display("FAIL reset_mid: q/busy/sout got %h/%b/%b expected 00/0/0", q, busy, sout); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (10) begin
      if (done || busy) dn++;
      @(posedge clk); #1;
    end
    n_vec++;
    if (dn != 0 || q !== '0) begin n_miss++; $display("FAIL reset_mid_after: active %0d q %h expected 0 and 00", dn, q); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) do_load(W'($urandom));
      else run_op(3'($urandom_range(0, 7)), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_load_shl();
    test_rotate_asr();
    test_priority();
    test_clamp();
    test_zero_back_to_back();
    test_ignored_during_shift();
    test_reset_mid_shift();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
